// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store front end for four byte-lane data memory banks.
// Lane i holds byte i of each little-endian 32-bit word. The banks sample on
// the falling clock edge, so strobes raised on a rising edge are seen half a
// cycle later. Read data is valid on the following rising edge.
module dmem_lsu #(
    parameter int ADDR_WIDTH = 13,
    parameter int BANK_DEPTH = 2**(ADDR_WIDTH-3)+1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [1:0]            REQ_SIZE,
    input  logic                  REQ_SIGNED,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [31:0]           REQ_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [31:0]           RSP_RDATA,
    output logic                  RSP_ERR,
    output logic [7:0]            ERR_COUNT,
    output logic [ADDR_WIDTH-1:0] B_ADDR,
    output logic [3:0]            B_WE,
    output logic [3:0]            B_RE,
    output logic [31:0]           B_DIN,
    input  logic [31:0]           B_DOUT
);

    localparam int          IDX_W   = ADDR_WIDTH - 2;
    localparam logic [31:0] DEPTH_U = 32'(BANK_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t state;

    // Request fields saved at accept; the live request inputs are ignored afterwards.
    logic       s_we;
    logic [1:0] s_size;
    logic       s_signed;
    logic [1:0] s_off;

    logic [IDX_W-1:0] req_idx;
    logic             req_err;
    logic [3:0]       st_lanes;
    logic [31:0]      st_data;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;

    assign REQ_READY = (state == IDLE);
    assign RSP_VALID = (state == RESP);
    assign req_idx   = REQ_ADDR[ADDR_WIDTH-1:2];

    // Reject illegal size, misalignment, and word indices beyond the banks.
    always_comb begin
        // NOTE: every variable written here gets a value first, so no path can infer a latch.
        req_err = 1'b0;
        case (REQ_SIZE)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = REQ_ADDR[0];
            2'b10:   req_err = |REQ_ADDR[1:0];
            default: req_err = 1'b1;
        endcase
        if ({{(32-IDX_W){1'b0}}, req_idx} >= DEPTH_U)
            req_err = 1'b1;
    end

    // Store lane enables and lane data: narrow data is replicated so every lane sees its byte.
    always_comb begin
        st_lanes = 4'b0000;
        st_data  = REQ_WDATA;
        case (REQ_SIZE)
            2'b00: begin
                st_lanes = 4'b0001 << REQ_ADDR[1:0];
                st_data  = {4{REQ_WDATA[7:0]}};
            end
            2'b01: begin
                st_lanes = REQ_ADDR[1] ? 4'b1100 : 4'b0011;
                st_data  = {2{REQ_WDATA[15:0]}};
            end
            default: begin
                st_lanes = 4'b1111;
                st_data  = REQ_WDATA;
            end
        endcase
    end

    // Pick the addressed lane(s) from the bank read data and extend to 32 bits.
    always_comb begin
        ld_byte = B_DOUT[{s_off, 3'b000} +: 8];
        ld_half = s_off[1] ? B_DOUT[31:16] : B_DOUT[15:0];
        case (s_size)
            2'b00:   ld_data = {{24{s_signed & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{s_signed & ld_half[15]}}, ld_half};
            default: ld_data = B_DOUT;
        endcase
    end

    // Request FSM with registered bank strobes and response outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            s_we      <= 1'b0;
            s_size    <= 2'b00;
            s_signed  <= 1'b0;
            s_off     <= 2'b00;
            RSP_RDATA <= 32'd0;
            RSP_ERR   <= 1'b0;
            ERR_COUNT <= 8'd0;
            B_ADDR    <= '0;
            B_WE      <= 4'b0000;
            B_RE      <= 4'b0000;
            B_DIN     <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        s_we     <= REQ_WE;
                        s_size   <= REQ_SIZE;
                        s_signed <= REQ_SIGNED;
                        s_off    <= REQ_ADDR[1:0];
                        if (req_err) begin
                            state     <= RESP;
                            RSP_ERR   <= 1'b1;
                            RSP_RDATA <= 32'd0;
                            if (ERR_COUNT != 8'hFF)
                                ERR_COUNT <= ERR_COUNT + 8'd1;
                        end else begin
                            state  <= ACCESS;
                            B_ADDR <= {req_idx, 2'b00};
                            if (REQ_WE) begin
                                B_WE  <= st_lanes;
                                B_DIN <= st_data;
                            end else begin
                                B_RE  <= 4'b1111;
                                B_DIN <= 32'd0;
                            end
                        end
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    B_WE      <= 4'b0000;
                    B_RE      <= 4'b0000;
                    RSP_ERR   <= 1'b0;
                    RSP_RDATA <= s_we ? 32'd0 : ld_data;
                end
                RESP: begin
                    if (RSP_READY)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed bench for dmem_lsu with a transaction-level model
// and a per-cycle compare process, plus hand-computed literal expectations.
module tb_dmem_lsu;

    logic        CLK;
    logic        RST;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [1:0]  REQ_SIZE;
    logic        REQ_SIGNED;
    logic [12:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic [7:0]  ERR_COUNT;
    logic [12:0] B_ADDR;
    logic [3:0]  B_WE;
    logic [3:0]  B_RE;
    logic [31:0] B_DIN;
    logic [31:0] B_DOUT;

    int n_checks = 0;
    int n_errors = 0;

    dmem_lsu #(.ADDR_WIDTH(13)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_SIZE(REQ_SIZE), .REQ_SIGNED(REQ_SIGNED), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .ERR_COUNT(ERR_COUNT),
        .B_ADDR(B_ADDR), .B_WE(B_WE), .B_RE(B_RE), .B_DIN(B_DIN), .B_DOUT(B_DOUT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic bit f_err(input logic [1:0] sz, input logic [12:0] a);
        int nb;
        if (sz == 2'd3) return 1'b1;
        nb = 1 << sz;
        if ((int'(a) % nb) != 0) return 1'b1;
        return (int'(a) / 4) >= 1025;
    endfunction

    function automatic logic [3:0] f_lanes(input logic [1:0] sz, input logic [12:0] a);
        int nb;
        nb = 1 << sz;
        return 4'(((1 << nb) - 1) << (int'(a) % 4));
    endfunction

    function automatic logic [31:0] f_din(input logic [1:0] sz, input logic [31:0] w);
        int nb;
        logic [31:0] v, r, mask;
        nb = 1 << sz;
        if (nb >= 4) return w;
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v = w & mask;
        r = 32'd0;
        for (int k = 0; k < 4; k += nb) r = r | (v << (8 * k));
        return r;
    endfunction

    function automatic logic [31:0] f_rdata(input logic [1:0] sz, input logic sgn,
                                            input logic [12:0] a, input logic [31:0] d);
        int nb;
        logic [31:0] v, mask;
        nb = 1 << sz;
        if (nb >= 4) return d;
        v = d >> (8 * (int'(a) % 4));
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v = v & mask;
        if (sgn && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- transaction model ----------------
    // One outstanding request; its age counts rising edges since acceptance.
    logic        m_busy;
    int          m_age;
    int          m_cnt;
    logic        m_err;
    logic        m_we;
    logic [1:0]  m_size;
    logic        m_sgn;
    logic [12:0] m_addr;
    logic [3:0]  m_lanes;
    logic [31:0] m_din;
    logic [31:0] m_rdata;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_busy <= 1'b0;
            m_age  <= 0;
            m_cnt  <= 0;
            m_err  <= 1'b0;
        end else if (!m_busy) begin
            if (REQ_VALID) begin
                m_busy  <= 1'b1;
                m_age   <= 0;
                m_we    <= REQ_WE;
                m_size  <= REQ_SIZE;
                m_sgn   <= REQ_SIGNED;
                m_addr  <= REQ_ADDR;
                m_err   <= f_err(REQ_SIZE, REQ_ADDR);
                m_lanes <= f_lanes(REQ_SIZE, REQ_ADDR);
                m_din   <= f_din(REQ_SIZE, REQ_WDATA);
                if (f_err(REQ_SIZE, REQ_ADDR) && m_cnt < 255) m_cnt <= m_cnt + 1;
            end
        end else if (m_age >= (m_err ? 0 : 1) && RSP_READY) begin
            m_busy <= 1'b0;
        end else begin
            if (m_age == 0 && !m_err) m_rdata <= f_rdata(m_size, m_sgn, m_addr, B_DOUT);
            m_age <= m_age + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic        e_strobe;
    logic        e_rsp;
    logic [12:0] e_baddr;

    always @(negedge CLK) begin
        if (!RST) begin
            e_strobe = m_busy && !m_err && m_age == 0;
            e_rsp    = m_busy && m_age >= (m_err ? 0 : 1);
            e_baddr  = 13'((int'(m_addr) / 4) * 4);
            check("req_ready", 32'(REQ_READY), 32'(!m_busy));
            check("rsp_valid", 32'(RSP_VALID), 32'(e_rsp));
            check("b_we", 32'(B_WE), 32'((e_strobe && m_we) ? m_lanes : 4'b0000));
            check("b_re", 32'(B_RE), 32'((e_strobe && !m_we) ? 4'b1111 : 4'b0000));
            check("err_count", 32'(ERR_COUNT), 32'(m_cnt));
            if (e_strobe) check("b_addr", 32'(B_ADDR), 32'(e_baddr));
            if (e_strobe && m_we) check("b_din", B_DIN, m_din);
            if (e_rsp) begin
                check("rsp_err", 32'(RSP_ERR), 32'(m_err));
                check("rsp_rdata", RSP_RDATA, (m_err || m_we) ? 32'd0 : m_rdata);
            end
        end
    end

    // ---------------- directed driver ----------------
    task automatic do_req(input string name, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [12:0] addr, input logic [31:0] wdata,
                          input logic [31:0] dout, input int hold, input logic [3:0] exp_we,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        @(negedge CLK);
        REQ_VALID  = 1'b1;
        REQ_WE     = we;
        REQ_SIZE   = size;
        REQ_SIGNED = sgn;
        REQ_ADDR   = addr;
        REQ_WDATA  = wdata;
        B_DOUT     = dout;
        RSP_READY  = (hold == 0);
        @(negedge CLK);
        REQ_VALID  = 1'b0;
        REQ_WE     = ~we;
        REQ_SIZE   = ~size;
        REQ_SIGNED = ~sgn;
        REQ_ADDR   = ~addr;
        REQ_WDATA  = ~wdata;
        check({name, ".we"}, 32'(B_WE), 32'(exp_we));
        n = 0;
        while (!RSP_VALID && n < 8) begin
            @(negedge CLK);
            n++;
        end
        if (!RSP_VALID) begin
            check({name, ".timeout"}, 32'(RSP_VALID), 32'd1);
        end else begin
            check({name, ".rdata"}, RSP_RDATA, exp_rdata);
            check({name, ".err"}, 32'(RSP_ERR), 32'(exp_err));
        end
        B_DOUT = ~dout;
        repeat (hold) @(negedge CLK);
        RSP_READY = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        RST        = 1'b0;
        REQ_VALID  = 1'b0;
        REQ_WE     = 1'b0;
        REQ_SIZE   = 2'b00;
        REQ_SIGNED = 1'b0;
        REQ_ADDR   = 13'd0;
        REQ_WDATA  = 32'd0;
        RSP_READY  = 1'b1;
        B_DOUT     = 32'd0;
        #1 RST = 1'b1;
        #2;
        check("rst.req_ready", 32'(REQ_READY), 32'd1);
        check("rst.rsp_valid", 32'(RSP_VALID), 32'd0);
        check("rst.rsp_err", 32'(RSP_ERR), 32'd0);
        check("rst.rsp_rdata", RSP_RDATA, 32'd0);
        check("rst.err_count", 32'(ERR_COUNT), 32'd0);
        check("rst.b_we", 32'(B_WE), 32'd0);
        check("rst.b_re", 32'(B_RE), 32'd0);
        check("rst.b_addr", 32'(B_ADDR), 32'd0);
        check("rst.b_din", B_DIN, 32'd0);
        #9 RST = 1'b0;

        // Stores
        do_req("st_word", 1'b1, 2'b10, 1'b0, 13'h010, 32'h11223344, 32'h0, 0, 4'b1111, 32'h0, 1'b0);
        do_req("st_byte", 1'b1, 2'b00, 1'b0, 13'h013, 32'h000000A5, 32'h0, 0, 4'b1000, 32'h0, 1'b0);
        do_req("st_half", 1'b1, 2'b01, 1'b0, 13'h012, 32'h0000BEEF, 32'h0, 0, 4'b1100, 32'h0, 1'b0);

        // Loads against a fixed bank word
        do_req("ld_sb13", 1'b0, 2'b00, 1'b1, 13'h013, 32'h0, 32'h80FF7F01, 0, 4'b0000, 32'hFFFFFF80, 1'b0);
        do_req("ld_ub13", 1'b0, 2'b00, 1'b0, 13'h013, 32'h0, 32'h80FF7F01, 0, 4'b0000, 32'h00000080, 1'b0);
        do_req("ld_sb11", 1'b0, 2'b00, 1'b1, 13'h011, 32'h0, 32'h80FF7F01, 0, 4'b0000, 32'h0000007F, 1'b0);
        do_req("ld_sh12", 1'b0, 2'b01, 1'b1, 13'h012, 32'h0, 32'h80FF7F01, 0, 4'b0000, 32'hFFFF80FF, 1'b0);
        do_req("ld_uh12", 1'b0, 2'b01, 1'b0, 13'h012, 32'h0, 32'h80FF7F01, 0, 4'b0000, 32'h000080FF, 1'b0);
        do_req("ld_sh10", 1'b0, 2'b01, 1'b1, 13'h010, 32'h0, 32'h80FF7F01, 0, 4'b0000, 32'h00007F01, 1'b0);
        // Word load held under backpressure for three cycles
        do_req("ld_w_bp", 1'b0, 2'b10, 1'b0, 13'h010, 32'h0, 32'h80FF7F01, 3, 4'b0000, 32'h80FF7F01, 1'b0);

        // Highest legal word index
        do_req("st_1000", 1'b1, 2'b10, 1'b0, 13'h1000, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'h0, 1'b0);
        do_req("ld_1000", 1'b0, 2'b10, 1'b1, 13'h1000, 32'h0, 32'hCAFEF00D, 0, 4'b0000, 32'hCAFEF00D, 1'b0);

        // Errors
        check("pre_err.count", 32'(ERR_COUNT), 32'd0);
        do_req("err_h11", 1'b0, 2'b01, 1'b1, 13'h011, 32'h0, 32'h80FF7F01, 0, 4'b0000, 32'h0, 1'b1);
        check("err_h11.count", 32'(ERR_COUNT), 32'd1);
        do_req("err_1004", 1'b1, 2'b10, 1'b0, 13'h1004, 32'h12345678, 32'h0, 0, 4'b0000, 32'h0, 1'b1);
        do_req("err_w2", 1'b0, 2'b10, 1'b0, 13'h012, 32'h0, 32'h80FF7F01, 0, 4'b0000, 32'h0, 1'b1);
        do_req("err_1fff", 1'b0, 2'b00, 1'b0, 13'h1FFF, 32'h0, 32'h80FF7F01, 0, 4'b0000, 32'h0, 1'b1);
        do_req("err_sz3", 1'b1, 2'b11, 1'b0, 13'h010, 32'h55555555, 32'h0, 0, 4'b0000, 32'h0, 1'b1);
        check("err_sz3.count", 32'(ERR_COUNT), 32'd5);
        for (int i = 0; i < 256; i++)
            do_req("err_sat", 1'b0, 2'b11, 1'b0, 13'(i * 4), 32'h0, 32'h0, 0, 4'b0000, 32'h0, 1'b1);
        check("err_sat.count", 32'(ERR_COUNT), 32'd255);

        // Reset during the bank access of a word store
        @(negedge CLK);
        REQ_VALID  = 1'b1;
        REQ_WE     = 1'b1;
        REQ_SIZE   = 2'b10;
        REQ_SIGNED = 1'b0;
        REQ_ADDR   = 13'h010;
        REQ_WDATA  = 32'hA1B2C3D4;
        RSP_READY  = 1'b1;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        check("rst_mid.we_before", 32'(B_WE), 32'hF);
        #2 RST = 1'b1;
        #1;
        check("rst_mid.we", 32'(B_WE), 32'd0);
        check("rst_mid.re", 32'(B_RE), 32'd0);
        check("rst_mid.rsp_valid", 32'(RSP_VALID), 32'd0);
        check("rst_mid.req_ready", 32'(REQ_READY), 32'd1);
        check("rst_mid.err_count", 32'(ERR_COUNT), 32'd0);
        #1 RST = 1'b0;

        do_req("post_rst", 1'b0, 2'b01, 1'b1, 13'h012, 32'h0, 32'h80FF7F01, 0, 4'b0000, 32'hFFFF80FF, 1'b0);
        repeat (2) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store front end for the four byte-lane data memory banks (lane i holds byte i of each little-endian 32-bit word).
- Accepts one byte, half or word request at a time from the pipeline MEM stage and drives the lane banks' address, enables and byte data.
- Banks sample on the falling CLK edge. This block works on the rising edge, so the four bank DOUTs are valid at the rising edge after the strobe cycle.
- Returns sign- or zero-extended load data, or a write acknowledge, with an error flag for misaligned or out-of-range accesses.

Parameters:
- ADDR_WIDTH, 13, byte-address width; banks index with ADDR[ADDR_WIDTH-1:2].
- BANK_DEPTH, 2**(ADDR_WIDTH-3)+1, number of words per bank; word index must be < BANK_DEPTH.

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous active-high reset
- REQ_VALID  in  1  request valid
- REQ_READY  out  1  block can accept a request
- REQ_WE  in  1  1=store, 0=load
- REQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal
- REQ_SIGNED  in  1  load sign-extend (ignored for stores)
- REQ_ADDR  in  ADDR_WIDTH  byte address
- REQ_WDATA  in  32  store data, right-justified
- RSP_VALID  out  1  response valid
- RSP_READY  in  1  consumer accepts response
- RSP_RDATA  out  32  extended load data; 0 for stores and errors
- RSP_ERR  out  1  access rejected
- ERR_COUNT  out  8  saturating count of rejected requests
- B_ADDR  out  ADDR_WIDTH  shared bank address (W_ADDR=R_ADDR) = {word index, 2'b00}
- B_WE  out  4  per-lane WRITE_EN
- B_RE  out  4  per-lane READ_EN
- B_DIN  out  32  lane i data on bits [8i+7:8i]
- B_DOUT  in  32  lane i read data on bits [8i+7:8i]

Behaviour:
- Reset (asynchronous, immediate): state IDLE, REQ_READY=1 after reset, RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0, ERR_COUNT=0, B_WE=0, B_RE=0, B_ADDR=0, B_DIN=0.
- Reset mid-ACCESS clears strobes at once. If RST is asserted before the falling edge, no bank write occurs.
- States: IDLE, ACCESS, RESP.
- REQ_READY = (state==IDLE). A request is accepted on the rising edge where REQ_VALID && REQ_READY.
- Error check at accept; any one of these rejects the request:
  - REQ_SIZE==11
  - half access with ADDR[0]=1
  - word access with ADDR[1:0]!=0
  - REQ_ADDR[ADDR_WIDTH-1:2] >= BANK_DEPTH
- On error: IDLE->RESP directly, RSP_ERR=1, RSP_RDATA=0, no B_WE/B_RE asserted, ERR_COUNT += 1 (saturates at 255).
- Valid accept: IDLE->ACCESS. Registered outputs are held for exactly one cycle:
  - Store lane enables: byte -> lane ADDR[1:0]; half -> lanes {2*ADDR[1], 2*ADDR[1]+1}; word -> 1111.
  - Store data: byte replicated to all lanes; half replicated to both halves; word as-is.
  - Loads: B_RE=1111, B_WE=0000.
- ACCESS->RESP on the next rising edge. On that edge:
  - Strobes drop to 0.
  - Loads capture B_DOUT, select the lane(s) by saved ADDR[1:0] and SIZE, and sign- or zero-extend per saved SIGNED into RSP_RDATA.
  - Stores set RSP_RDATA=0 and RSP_ERR=0.
- RSP_VALID is high in RESP. RSP_RDATA and RSP_ERR stay stable until an edge with RSP_READY=1, then RESP->IDLE.
- No new request is accepted in the cycle the response retires (REQ_READY follows the state).
- Latency, accept edge to RSP_VALID: 2 edges for valid accesses, 1 edge for errors. Throughput is at most 1 request per 3 cycles with RSP_READY tied high.
- Request inputs are sampled only at accept; later changes are ignored.

Test Plan:
- Word store REQ_ADDR=0x010, WDATA=0x11223344 -> next cycle B_ADDR=0x010, B_WE=1111, B_DIN=0x11223344 for one cycle; then RSP_VALID=1, RSP_ERR=0, RSP_RDATA=0.
- Byte store 0xA5 at 0x013 -> B_WE=1000, B_DIN=0xA5A5A5A5, B_ADDR=0x010. Half store 0xBEEF at 0x012 -> B_WE=1100, B_DIN=0xBEEFBEEF.
- Loads with B_DOUT=0x80FF7F01:
  - signed byte @0x013 -> 0xFFFFFF80
  - unsigned byte @0x013 -> 0x00000080
  - signed half @0x012 -> 0xFFFF80FF
  - signed half @0x010 -> 0x00007F01
  - word @0x010 -> 0x80FF7F01
- Errors:
  - half @0x011 -> RSP_VALID one edge after accept, RSP_ERR=1, B_WE=B_RE=0000, ERR_COUNT 0->1
  - word @0x1004 (index 1025) -> error
  - word @0x1000 (index 1024) -> succeeds
  - SIZE=11 -> error
  - 256 errors -> ERR_COUNT holds 255
- Backpressure: RSP_READY low 3 cycles after a load -> RSP_VALID, RSP_RDATA stable and REQ_READY=0 throughout; REQ_READY=1 the edge after RSP_READY=1.
- Reset mid-operation: RST pulsed during ACCESS of a word store -> B_WE=0000 immediately, RSP_VALID=0, REQ_READY=1 after release; next request proceeds normally.
